// File: rtl/bios_sink.sv
// bios_sink: consuming end of the BIOS loader handshake. Buffers words in a
// 4-entry FIFO, writes them to boot memory and releases the CPU when complete.
// Define BIOS_SINK_CHECKSUM_EN to require a zero byte-sum before releasing the CPU.
`timescale 1ns/1ps
module bios_sink #(
    parameter int          NWORDS = 4096,
    parameter logic [19:0] BASE   = 20'hFE000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [12:0] bios_addr,
    input  logic [15:0] bios_din,
    input  logic        bios_wr,
    output logic        bios_req,
    output logic [19:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [7:0]  checksum
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_reg, state_next;
    logic [13:0] expected_reg, expected_next;
    logic [2:0]  count_reg, count_next;
    logic [1:0]  wr_ptr_reg, wr_ptr_next;
    logic [1:0]  rd_ptr_reg, rd_ptr_next;
    logic        bios_req_reg, bios_req_next;
    logic [19:0] fifo_addr [4];
    logic [15:0] fifo_data [4];
    logic        accept, addr_match, push, pop, last_word, image_ok;

    assign accept     = bios_req_reg & bios_wr;
    assign addr_match = ({1'b0, bios_addr} == expected_reg);
    assign push       = accept & addr_match;
    assign pop        = mem_we & mem_ack;
    assign last_word  = (expected_reg == 14'(NWORDS - 1));

`ifdef BIOS_SINK_CHECKSUM_EN
    logic [7:0] sum_reg, sum_next;

    // Every accepted word contributes, including one with a bad address.
    always_comb begin
        sum_next = sum_reg;
        if (accept) begin
            sum_next = sum_reg + bios_din[7:0] + bios_din[15:8];
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sum_reg <= 8'h00;
        end else begin
            sum_reg <= sum_next;
        end
    end

    assign checksum = sum_reg;
    assign image_ok = (sum_reg == 8'h00);
`else
    assign checksum = 8'h00;
    assign image_ok = 1'b1;
`endif

    always_comb begin
        state_next    = state_reg;
        expected_next = expected_reg;
        case (state_reg)
            S_IDLE: state_next = S_LOAD;
            S_LOAD: begin
                if (accept) begin
                    if (!addr_match) begin
                        state_next = S_ERR;
                    end else begin
                        expected_next = expected_reg + 14'd1;
                        if (last_word) begin
                            state_next = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (count_reg == 3'd0) begin
                    state_next = image_ok ? S_DONE : S_ERR;
                end
            end
            default: state_next = state_reg;
        endcase
    end

    // In ERR the head write is allowed to finish; its ack discards the rest.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (state_reg == S_ERR) begin
            if (pop) begin
                rd_ptr_next = wr_ptr_reg;
                count_next  = 3'd0;
            end
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 2'd1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 2'd1;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 3'd1;
                2'b01:   count_next = count_reg - 3'd1;
                default: count_next = count_reg;
            endcase
        end
        // Leaving one free slot behind the request covers the word that may
        // land on the edge where the request is seen high.
        bios_req_next = (state_reg == S_LOAD) && (state_next == S_LOAD) &&
                        (count_next <= 3'd2);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            expected_reg <= 14'd0;
            count_reg    <= 3'd0;
            wr_ptr_reg   <= 2'd0;
            rd_ptr_reg   <= 2'd0;
            bios_req_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            expected_reg <= expected_next;
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            bios_req_reg <= bios_req_next;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr_reg] <= BASE + {6'd0, expected_reg};
            fifo_data[wr_ptr_reg] <= bios_din;
        end
    end

    assign bios_req = bios_req_reg;
    assign mem_we   = (count_reg != 3'd0);
    assign mem_addr = mem_we ? fifo_addr[rd_ptr_reg] : 20'd0;
    assign mem_data = mem_we ? fifo_data[rd_ptr_reg] : 16'd0;
    assign cpu_hold = (state_reg != S_DONE);
    assign done     = (state_reg == S_DONE);
    assign err      = (state_reg == S_ERR);
endmodule

// File: tb/tb_bios_sink.sv
// tb_bios_sink: vector table for the nominal load, directed corner sequences,
// then randomized loads checked against a word-level model of the loader.
`timescale 1ns/1ps
module tb_bios_sink;
    localparam int          NW   = 4;
    localparam logic [19:0] BASE = 20'hFE000;
`ifdef BIOS_SINK_CHECKSUM_EN
    localparam logic [15:0] W3    = 16'h9600;
    localparam bit          CK_ON = 1'b1;
`else
    localparam logic [15:0] W3    = 16'hDEF0;
    localparam bit          CK_ON = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [12:0] bios_addr = '0;
    logic [15:0] bios_din  = '0;
    logic        bios_wr   = 1'b0;
    logic        bios_req;
    logic [19:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic        mem_ack   = 1'b0;
    logic        cpu_hold, done, err;
    logic [7:0]  checksum;

    always #5 clk_sys = ~clk_sys;

    bios_sink #(.NWORDS(NW), .BASE(BASE)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .bios_addr(bios_addr),
        .bios_din (bios_din),
        .bios_wr  (bios_wr),
        .bios_req (bios_req),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .mem_ack  (mem_ack),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .checksum (checksum)
    );

    typedef struct packed {
        logic [19:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct packed {
        logic        wr;
        logic [12:0] addr;
        logic [15:0] din;
        logic        ack;
        logic        req;
        logic        we;
        logic [19:0] maddr;
        logic [15:0] mdata;
        logic        done;
        logic        hold;
        logic [7:0]  ck;
    } vec_t;

    wr_t         wr_log[$];
    logic [15:0] nom[NW];
    logic [15:0] src[NW];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          k, e_cnt, bad_at;
    bit          err_seen;
    logic [7:0]  acc_sum;

    // Completed memory writes, in order.
    always @(posedge clk_sys) begin
        if (!reset && mem_we && mem_ack) begin
            wr_log.push_back('{addr: mem_addr, data: mem_data});
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, required to finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ckx(input logic [7:0] v);
        return CK_ON ? v : 8'h00;
    endfunction

    task automatic step();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic clear_model();
        wr_log.delete();
        k        = 0;
        e_cnt    = 0;
        err_seen = 1'b0;
        acc_sum  = 8'h00;
        bad_at   = -1;
    endtask

    task automatic apply_reset();
        @(negedge clk_sys);
        reset = 1'b1; bios_wr = 1'b0; bios_addr = '0; bios_din = '0; mem_ack = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        clear_model();
        reset = 1'b0;
    endtask

    // Request rule seen from outside: up from the second edge after reset,
    // down when 3+ words are unwritten, after the last word, or after an error.
    task automatic check_req(input string tag);
        bit exp_req;
        exp_req = (e_cnt >= 2) && !err_seen && (k < NW) && ((k - wr_log.size()) <= 2);
        chk({tag, ".req"}, 32'(bios_req), 32'(exp_req));
    endtask

    // One source cycle: present word k (wrong address at bad_at), hold until accepted.
    task automatic src_cycle(input string tag, input bit rnd);
        bit acc;
        bios_wr   = (k < NW) && !err_seen && (!rnd || ($urandom_range(0, 3) != 0));
        bios_addr = 13'((k == bad_at) ? k + 1 : k);
        bios_din  = src[(k < NW) ? k : 0];
        acc = bios_req && bios_wr;
        step();
        e_cnt++;
        if (acc) begin
            acc_sum = acc_sum + bios_din[7:0] + bios_din[15:8];
            if (k == bad_at) err_seen = 1'b1;
            else k++;
        end
        check_req(tag);
    endtask

    task automatic run_until_end(input string tag, input bit rnd);
        int n;
        n = 0;
        while (!((done || err) && !mem_we) && n < 300) begin
            if (rnd) mem_ack = ($urandom_range(0, 2) != 0);
            src_cycle(tag, rnd);
            n++;
        end
        chk({tag, ".ended"}, 32'(done || err), 32'd1);
        bios_wr = 1'b0;
    endtask

    task automatic check_entries(input string tag);
        foreach (wr_log[j]) begin
            if (j < NW) begin
                chk($sformatf("%s.w%0d.addr", tag, j), 32'(wr_log[j].addr), 32'(BASE + 20'(j)));
                chk($sformatf("%s.w%0d.data", tag, j), 32'(wr_log[j].data), 32'(src[j]));
            end
        end
    endtask

    initial begin
        vec_t vt[9];
        nom[0] = 16'h1234; nom[1] = 16'h5678; nom[2] = 16'h9ABC; nom[3] = W3;
        //           wr    addr   din       ack   req   we    maddr         mdata     done  hold  ck
        vt[0] = '{1'b0, 13'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 20'h0,        16'h0000, 1'b0, 1'b1, 8'h00};
        vt[1] = '{1'b0, 13'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 20'h0,        16'h0000, 1'b0, 1'b1, 8'h00};
        vt[2] = '{1'b1, 13'd0, 16'h1234, 1'b1, 1'b1, 1'b1, BASE,         16'h1234, 1'b0, 1'b1, ckx(8'h46)};
        vt[3] = '{1'b1, 13'd1, 16'h5678, 1'b1, 1'b1, 1'b1, BASE + 20'd1, 16'h5678, 1'b0, 1'b1, ckx(8'h14)};
        vt[4] = '{1'b1, 13'd2, 16'h9ABC, 1'b1, 1'b1, 1'b1, BASE + 20'd2, 16'h9ABC, 1'b0, 1'b1, ckx(8'h6A)};
        vt[5] = '{1'b1, 13'd3, W3,       1'b1, 1'b0, 1'b1, BASE + 20'd3, W3,       1'b0, 1'b1, 8'h00};
        vt[6] = '{1'b0, 13'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 20'h0,        16'h0000, 1'b0, 1'b1, 8'h00};
        vt[7] = '{1'b0, 13'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 20'h0,        16'h0000, 1'b1, 1'b0, 8'h00};
        vt[8] = '{1'b1, 13'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 20'h0,        16'h0000, 1'b1, 1'b0, 8'h00};

        // Reset values
        clear_model();
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("rst.req", 32'(bios_req), 32'd0);
        chk("rst.we", 32'(mem_we), 32'd0);
        chk("rst.addr", 32'(mem_addr), 32'd0);
        chk("rst.data", 32'(mem_data), 32'd0);
        chk("rst.hold", 32'(cpu_hold), 32'd1);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.ck", 32'(checksum), 32'd0);
        reset = 1'b0;

        // Nominal load plus post-done noise, cycle by cycle
        for (int i = 0; i < 9; i++) begin
            bios_wr = vt[i].wr; bios_addr = vt[i].addr; bios_din = vt[i].din; mem_ack = vt[i].ack;
            step();
            chk($sformatf("vec%0d.req", i), 32'(bios_req), 32'(vt[i].req));
            chk($sformatf("vec%0d.we", i), 32'(mem_we), 32'(vt[i].we));
            if (vt[i].we) begin
                chk($sformatf("vec%0d.maddr", i), 32'(mem_addr), 32'(vt[i].maddr));
                chk($sformatf("vec%0d.mdata", i), 32'(mem_data), 32'(vt[i].mdata));
            end
            chk($sformatf("vec%0d.done", i), 32'(done), 32'(vt[i].done));
            chk($sformatf("vec%0d.hold", i), 32'(cpu_hold), 32'(vt[i].hold));
            chk($sformatf("vec%0d.err", i), 32'(err), 32'd0);
            chk($sformatf("vec%0d.ck", i), 32'(checksum), 32'(vt[i].ck));
        end
        src = nom;
        chk("nom.nwrites", 32'(wr_log.size()), 32'd4);
        check_entries("nom");

        // Memory stall: ack held low while the source streams
        apply_reset();
        src = nom;
        mem_ack = 1'b0;
        for (int c = 0; c < 22; c++) src_cycle("stall", 1'b0);
        chk("stall.accepts", 32'(k), 32'd3);
        chk("stall.nwrites_during", 32'(wr_log.size()), 32'd0);
        chk("stall.req", 32'(bios_req), 32'd0);
        chk("stall.we_held", 32'(mem_we), 32'd1);
        chk("stall.head_addr", 32'(mem_addr), 32'(BASE));
        chk("stall.head_data", 32'(mem_data), 32'(nom[0]));
        mem_ack = 1'b1;
        run_until_end("stall", 1'b0);
        chk("stall.nwrites", 32'(wr_log.size()), 32'd4);
        check_entries("stall");
        chk("stall.done", 32'(done), 32'd1);

        // Address skip: addr 2 presented while word 1 is expected
        apply_reset();
        src = nom;
        bad_at = 1;
        mem_ack = 1'b1;
        for (int c = 0; c < 20 && !err_seen; c++) src_cycle("skip", 1'b0);
        chk("skip.err", 32'(err), 32'd1);
        chk("skip.req", 32'(bios_req), 32'd0);
        chk("skip.hold", 32'(cpu_hold), 32'd1);
        chk("skip.done", 32'(done), 32'd0);
        run_until_end("skip", 1'b0);
        repeat (3) step();
        chk("skip.nwrites", 32'(wr_log.size()), 32'd1);
        check_entries("skip");
        chk("skip.err_stays", 32'(err), 32'd1);

`ifdef BIOS_SINK_CHECKSUM_EN
        // Checksum failure: one byte off by one
        apply_reset();
        src = nom;
        src[0] = 16'h1235;
        mem_ack = 1'b1;
        run_until_end("ckfail", 1'b0);
        chk("ckfail.err", 32'(err), 32'd1);
        chk("ckfail.done", 32'(done), 32'd0);
        chk("ckfail.ck", 32'(checksum), 32'h01);
        chk("ckfail.hold", 32'(cpu_hold), 32'd1);
`endif

        // Reset in the middle of the third write
        apply_reset();
        src = nom;
        mem_ack = 1'b1;
        for (int c = 0; c < 20 && !(mem_we && mem_addr == BASE + 20'd2); c++) src_cycle("rstmid", 1'b0);
        chk("rstmid.third_write", 32'(mem_addr), 32'(BASE + 20'd2));
        bios_wr = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rstmid.we", 32'(mem_we), 32'd0);
        chk("rstmid.req", 32'(bios_req), 32'd0);
        chk("rstmid.addr", 32'(mem_addr), 32'd0);
        chk("rstmid.hold", 32'(cpu_hold), 32'd1);
        @(negedge clk_sys);
        clear_model();
        reset = 1'b0;
        step();
        chk("rstmid.req_e1", 32'(bios_req), 32'd0);
        step();
        chk("rstmid.req_e2", 32'(bios_req), 32'd1);
        e_cnt = 2;
        run_until_end("rstmid", 1'b0);
        chk("rstmid.nwrites", 32'(wr_log.size()), 32'd4);
        check_entries("rstmid");
        chk("rstmid.done", 32'(done), 32'd1);

        // Noise after DONE
        for (int c = 0; c < 3; c++) begin
            bios_wr = 1'b1; bios_addr = 13'd0; bios_din = 16'h1234;
            step();
            chk($sformatf("noise%0d.we", c), 32'(mem_we), 32'd0);
            chk($sformatf("noise%0d.done", c), 32'(done), 32'd1);
        end
        bios_wr = 1'b0;
        chk("noise.nwrites", 32'(wr_log.size()), 32'd4);

        // Randomized loads against the word-level model
        for (int t = 0; t < 30; t++) begin
            logic [7:0] s;
            apply_reset();
            s = 8'h00;
            for (int i = 0; i < NW; i++) src[i] = 16'($urandom);
            bad_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NW - 1)) : -1;
            if (CK_ON && bad_at < 0) begin
                for (int i = 0; i < NW - 1; i++) s = s + src[i][7:0] + src[i][15:8];
                src[NW - 1] = {8'h00, 8'h00 - s};
            end
            run_until_end($sformatf("rnd%0d", t), 1'b1);
            if (bad_at >= 0) begin
                chk($sformatf("rnd%0d.err", t), 32'(err), 32'd1);
                chk($sformatf("rnd%0d.done", t), 32'(done), 32'd0);
                chk($sformatf("rnd%0d.hold", t), 32'(cpu_hold), 32'd1);
                chk($sformatf("rnd%0d.nwrites_le", t), 32'(wr_log.size() <= bad_at), 32'd1);
            end else begin
                chk($sformatf("rnd%0d.done", t), 32'(done), 32'd1);
                chk($sformatf("rnd%0d.err", t), 32'(err), 32'd0);
                chk($sformatf("rnd%0d.hold", t), 32'(cpu_hold), 32'd0);
                chk($sformatf("rnd%0d.nwrites", t), 32'(wr_log.size()), 32'(NW));
            end
            chk($sformatf("rnd%0d.ck", t), 32'(checksum), 32'(ckx(acc_sum)));
            check_entries($sformatf("rnd%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
